// File: rtl/lsb_queue_if.sv
// lsb_queue_if: dispatch, CDB, commit, memory and load-result signals of the load/store buffer
interface lsb_queue_if #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                     flush;
  logic                     enq_valid;
  logic                     enq_ready;
  logic                     enq_is_load;
  logic [TAG_W-1:0]         enq_tag;
  logic [2:0]               enq_funct3;
  logic [ADDR_W-1:0]        enq_addr;
  logic [DATA_W-1:0]        enq_data;
  logic                     enq_data_ok;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_value;
  logic                     commit_valid;
  logic [TAG_W-1:0]         commit_tag;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_we;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic [DATA_W-1:0]        mem_req_wdata;
  logic [3:0]               mem_req_wstrb;
  logic                     mem_rsp_valid;
  logic [DATA_W-1:0]        mem_rsp_data;
  logic                     ld_valid;
  logic [TAG_W-1:0]         ld_tag;
  logic [DATA_W-1:0]        ld_value;
  logic [$clog2(DEPTH):0]   count;
  modport slave (
    input  flush, enq_valid, enq_is_load, enq_tag, enq_funct3, enq_addr, enq_data, enq_data_ok,
           cdb_valid, cdb_tag, cdb_value, commit_valid, commit_tag, mem_req_ready,
           mem_rsp_valid, mem_rsp_data,
    output enq_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
           ld_valid, ld_tag, ld_value, count
  );
  modport master (
    output flush, enq_valid, enq_is_load, enq_tag, enq_funct3, enq_addr, enq_data, enq_data_ok,
           cdb_valid, cdb_tag, cdb_value, commit_valid, commit_tag, mem_req_ready,
           mem_rsp_valid, mem_rsp_data,
    input  enq_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
           ld_valid, ld_tag, ld_value, count
  );
endinterface

// File: rtl/lsb_queue.sv
// lsb_queue: in-order circular load/store buffer issuing one memory request at a time from the head
module lsb_queue #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  lsb_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic [DEPTH-1:0] v, is_ld, rdy, cmt, keep, hmask;
  logic [TAG_W-1:0] tag [DEPTH];
  logic [2:0] f3 [DEPTH];
  logic [ADDR_W-1:0] addr [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] cnt, ncmt;
  logic drop, enq, issue, acc, deq, ld_done, cap;
  logic [2:0] req_f3, hf;
  logic [1:0] req_a, ha, lane, rl;
  logic [TAG_W-1:0] req_tag;
  logic st_b, st_h, ld_b, ld_h;
  logic [DATA_W-1:0] hd, wdata, rs, ld_val;
  logic [3:0] wstrb;
  assign q.count = cnt;
  assign q.enq_ready = !cnt[PW];
  assign enq = q.enq_valid && !cnt[PW] && !q.flush;
  assign cap = q.cdb_valid && q.cdb_tag == q.enq_tag;
  assign issue = state == IDLE && v[head] && rdy[head] && cmt[head] && !(q.flush && is_ld[head]);
  assign acc = state == REQ && q.mem_req_ready;
  assign ld_done = state == WAIT && q.mem_rsp_valid && !drop && !q.flush;
  assign deq = (acc && q.mem_req_we) || ld_done;
  // committed stores form a prefix from head, so flush keeps exactly these
  assign keep = v & ~is_ld & cmt;
  assign hmask = deq ? ({{(DEPTH-1){1'b0}}, 1'b1} << head) : '0;
  always_comb begin
    ncmt = '0;
    for (int i = 0; i < DEPTH; i++) ncmt = ncmt + {{PW{1'b0}}, keep[i]};
  end
  always_comb begin
    hf = f3[head];
    ha = addr[head][1:0];
    hd = data[head];
    st_b = hf == 3'd0;
    st_h = hf == 3'd1;
    lane = st_b ? ha : st_h ? {ha[1], 1'b0} : 2'b00;
    wstrb = st_b ? 4'b0001 << lane : st_h ? 4'b0011 << lane : 4'b1111;
    wdata = (st_b ? {24'b0, hd[7:0]} : st_h ? {16'b0, hd[15:0]} : hd) << {lane, 3'b000};
    ld_b = req_f3[1:0] == 2'd0;
    ld_h = req_f3[1:0] == 2'd1;
    rl = ld_b ? req_a : ld_h ? {req_a[1], 1'b0} : 2'b00;
    rs = q.mem_rsp_data >> {rl, 3'b000};
    ld_val = ld_b ? {{24{!req_f3[2] && rs[7]}}, rs[7:0]}
           : ld_h ? {{16{!req_f3[2] && rs[15]}}, rs[15:0]} : rs;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (issue ? REQ : IDLE)
             : state == REQ  ? (acc ? (q.mem_req_we ? IDLE : WAIT) : REQ)
             : (q.mem_rsp_valid ? IDLE : WAIT);
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      is_ld <= '0;
      rdy <= '0;
      cmt <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
      drop <= 1'b0;
      req_f3 <= '0;
      req_a <= '0;
      req_tag <= '0;
      q.mem_req_valid <= 1'b0;
      q.mem_req_we <= 1'b0;
      q.mem_req_addr <= '0;
      q.mem_req_wdata <= '0;
      q.mem_req_wstrb <= '0;
      q.ld_valid <= 1'b0;
      q.ld_tag <= '0;
      q.ld_value <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (v[i] && !is_ld[i] && !rdy[i] && q.cdb_valid && tag[i] == q.cdb_tag) begin
          data[i] <= q.cdb_value;
          rdy[i] <= 1'b1;
        end
        if (v[i] && !is_ld[i] && q.commit_valid && tag[i] == q.commit_tag) cmt[i] <= 1'b1;
      end
      if (enq) begin
        v[tail] <= 1'b1;
        is_ld[tail] <= q.enq_is_load;
        tag[tail] <= q.enq_tag;
        f3[tail] <= q.enq_funct3;
        addr[tail] <= q.enq_addr;
        data[tail] <= cap ? q.cdb_value : q.enq_data;
        rdy[tail] <= q.enq_is_load || cap || q.enq_data_ok;
        cmt[tail] <= q.enq_is_load;
        tail <= tail + 1'b1;
      end
      if (deq) begin
        v[head] <= 1'b0;
        head <= head + 1'b1;
      end
      cnt <= cnt + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
      if (q.flush) begin
        v <= keep & ~hmask;
        tail <= head + ncmt[PW-1:0];
        cnt <= ncmt - {{PW{1'b0}}, deq};
      end
      if (q.flush && ((state == REQ && !q.mem_req_we) || state == WAIT)) drop <= 1'b1;
      if (state == WAIT && q.mem_rsp_valid) drop <= 1'b0;
      if (issue) begin
        q.mem_req_valid <= 1'b1;
        q.mem_req_we <= !is_ld[head];
        q.mem_req_addr <= {addr[head][ADDR_W-1:2], 2'b00};
        q.mem_req_wdata <= is_ld[head] ? '0 : wdata;
        q.mem_req_wstrb <= is_ld[head] ? 4'b0000 : wstrb;
        req_f3 <= hf;
        req_a <= ha;
        req_tag <= tag[head];
      end
      if (acc) q.mem_req_valid <= 1'b0;
      q.ld_valid <= ld_done;
      if (ld_done) begin
        q.ld_tag <= req_tag;
        q.ld_value <= ld_val;
      end
    end
  end
endmodule
